node_tx_port: RTL and testbench

Output-side sender for one node port: buffers locally produced flits in a small FIFO and drives the flit/enable side of a node-to-node link, retiring a flit on `ack` and retransmitting it after a back-off on `rej`. It sits directly upstream of the inter-node link, between the node's routing/arbitration logic and the link wires. It also exposes occupancy and a saturating reject counter for debug.

---
 rtl/node_tx_port_if.sv | 25 ++
 rtl/node_tx_port.sv | 115 +++++++++++
 tb/tb_node_tx_port.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/node_tx_port_if.sv
// Link-side bundle for node_tx_port: the node-side push handshake plus the
// flit/enable/ack/rej wires of the node-to-node link.
interface node_tx_port_if #(
  parameter int FLIT_W = 32
) ();
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] flit;
  logic              enable;
  logic              ack;
  logic              rej;

  // Sender (the port itself)
  modport master (
    input  in_flit, in_valid, ack, rej,
    output in_ready, flit, enable
  );

  // Environment: node logic feeding flits and the receiver answering them
  modport slave (
    output in_flit, in_valid, ack, rej,
    input  in_ready, flit, enable
  );
endinterface

// File: rtl/node_tx_port.sv
// Output-side sender for one node port. Locally produced flits are queued in
// a small circular FIFO; the head is offered on the link and retired on ack,
// or re-offered after a back-off on rej. Occupancy and a saturating reject
// counter are exposed for debug.
module node_tx_port #(
  parameter int FLIT_W     = 32,
  parameter int DEPTH      = 4,
  parameter int RETRY_WAIT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  node_tx_port_if.master             link,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                rej_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [7:0]    WAIT_LOAD = (RETRY_WAIT == 0) ? 8'd0 : 8'(RETRY_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    BACKOFF
  } state_t;

  state_t            state, state_next;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q, count_next;
  logic [7:0]        wait_cnt, wait_next;
  logic [FLIT_W-1:0] last_flit;
  logic [15:0]       rej_cnt_q;
  logic              push, pop, reject;

  // in_ready comes only from the registered occupancy, so a pop does not
  // open a slot until the following cycle.
  assign link.in_ready = (count_q != FULL);
  assign push          = link.in_valid && link.in_ready;
  assign pop           = (state == SEND) && link.ack;
  assign reject        = (state == SEND) && link.rej && !link.ack;

  assign link.enable = (state == SEND);
  assign link.flit   = (state == SEND) ? mem[rd_ptr] : last_flit;
  assign count       = count_q;
  assign rej_cnt     = rej_cnt_q;

  // Occupancy after this cycle's push/pop; both together cancel out.
  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Next-state logic; ack has priority over rej when both arrive together.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      IDLE: begin
        if (count_next != '0) state_next = SEND;
      end
      SEND: begin
        if (link.ack) begin
          if (count_next == '0) state_next = IDLE;
        end else if (link.rej) begin
          if (RETRY_WAIT != 0) begin
            state_next = BACKOFF;
            wait_next  = WAIT_LOAD;
          end
        end
      end
      BACKOFF: begin
        if (wait_cnt == 8'd0) state_next = SEND;
        else                  wait_next  = wait_cnt - 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointers, occupancy and the debug reject counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rej_cnt_q <= 16'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      count_q  <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (reject && rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
    end
  end

  // Remember the flit being offered so the link wires hold it while idle.
  always_ff @(posedge clk) begin
    if (!rst_n)              last_flit <= '0;
    else if (state == SEND)  last_flit <= mem[rd_ptr];
  end

  // FIFO storage needs no reset; only occupied entries are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= link.in_flit;
  end

endmodule

// File: tb/tb_node_tx_port.sv
// Self-checking bench for node_tx_port: one instance with RETRY_WAIT = 3
// checked against a scoreboard of pushed flits, and one with RETRY_WAIT = 0
// for the immediate-retry and reject-counter saturation cases.
module tb_node_tx_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  count3, count0;
  logic [15:0] rej_cnt3, rej_cnt0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] sb_q[$];

  node_tx_port_if #(.FLIT_W(32)) if3 ();
  node_tx_port_if #(.FLIT_W(32)) if0 ();

  node_tx_port #(.FLIT_W(32), .DEPTH(4), .RETRY_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .link(if3.master), .count(count3), .rej_cnt(rej_cnt3)
  );

  node_tx_port #(.FLIT_W(32), .DEPTH(4), .RETRY_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .link(if0.master), .count(count0), .rej_cnt(rej_cnt0)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive all node/receiver inputs of the RETRY_WAIT=3 instance at once.
  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic a, input logic r);
    if3.in_valid = valid;
    if3.in_flit  = data;
    if3.ack      = a;
    if3.rej      = r;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack everything until the FIFO empties, with a bounded cycle budget.
  task automatic drain(input string tag);
    if3.ack = 1'b1;
    for (int i = 0; i < 40 && !(count3 == 3'd0 && !if3.enable); i++) tick();
    checkOutput(tag, {31'd0, (count3 == 3'd0 && !if3.enable)}, 32'd1);
    if3.ack = 1'b0;
  endtask

  // Scoreboard: record accepted pushes; compare every acked flit with the
  // oldest outstanding one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if3.enable && if3.ack) begin
        if (sb_q.size() == 0) checkOutput("sb_underflow", 32'd1, 32'd0);
        else                  checkOutput("sb_flit", if3.flit, sb_q.pop_front());
      end
      if (if3.in_valid && if3.in_ready) sb_q.push_back(if3.in_flit);
    end
  end

  initial begin
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    if0.in_valid = 1'b0;
    if0.in_flit  = 32'd0;
    if0.ack      = 1'b0;
    if0.rej      = 1'b0;

    // Reset held for two edges, then idle
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("rst_enable", {31'd0, if3.enable}, 32'd0);
    checkOutput("rst_flit", if3.flit, 32'd0);
    checkOutput("rst_count", {29'd0, count3}, 32'd0);
    checkOutput("rst_rej_cnt", {16'd0, rej_cnt3}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, if3.in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idle_enable", {31'd0, if3.enable}, 32'd0);
    end

    // Streaming: consecutive pushes, receiver acks every offer
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA0 + i, 1'b1, 1'b0);
      tick();
      checkOutput("stream_enable", {31'd0, if3.enable}, 32'd1);
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_end_enable", {31'd0, if3.enable}, 32'd0);
    checkOutput("stream_end_count", {29'd0, count3}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    tick();

    // Full / backpressure
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hB0 + i, 1'b0, 1'b0);
      tick();
    end
    checkOutput("full_count", {29'd0, count3}, 32'd4);
    checkOutput("full_in_ready", {31'd0, if3.in_ready}, 32'd0);
    applyStimulus(1'b1, 32'hB4, 1'b0, 1'b0);
    tick();
    checkOutput("held_count", {29'd0, count3}, 32'd4);
    checkOutput("held_flit", if3.flit, 32'hB0);
    applyStimulus(1'b1, 32'hB4, 1'b1, 1'b0);
    tick();
    checkOutput("pop_in_ready", {31'd0, if3.in_ready}, 32'd1);
    checkOutput("pop_count", {29'd0, count3}, 32'd3);
    applyStimulus(1'b1, 32'hB4, 1'b0, 1'b0);
    tick();
    checkOutput("refill_count", {29'd0, count3}, 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    drain("full_drain");

    // Reject and back-off
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h66, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("rej_pre_flit", if3.flit, 32'h55);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("rej_cnt_one", {16'd0, rej_cnt3}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("backoff_enable", {31'd0, if3.enable}, 32'd0);
      checkOutput("backoff_flit_hold", if3.flit, 32'h55);
      tick();
    end
    checkOutput("retry_enable", {31'd0, if3.enable}, 32'd1);
    checkOutput("retry_flit", if3.flit, 32'h55);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("after_retry_enable", {31'd0, if3.enable}, 32'd1);
    checkOutput("after_retry_flit", if3.flit, 32'h66);
    drain("rej_drain");

    // ack and rej together behave as ack
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("both_rej_cnt", {16'd0, rej_cnt3}, 32'd1);
    checkOutput("both_count", {29'd0, count3}, 32'd0);
    checkOutput("both_enable", {31'd0, if3.enable}, 32'd0);

    // ack while enable is low is ignored
    applyStimulus(1'b1, 32'h88, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("stray_ack_count", {29'd0, count3}, 32'd1);
    checkOutput("stray_ack_enable", {31'd0, if3.enable}, 32'd0);
    checkOutput("stray_rej_cnt", {16'd0, rej_cnt3}, 32'd2);
    tick();
    tick();
    checkOutput("stray_retry_flit", if3.flit, 32'h88);
    drain("stray_drain");

    // Reset in the middle of a back-off with three flits buffered
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hC0 + i, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb_q.delete();
    checkOutput("midrst_enable", {31'd0, if3.enable}, 32'd0);
    checkOutput("midrst_count", {29'd0, count3}, 32'd0);
    checkOutput("midrst_rej_cnt", {16'd0, rej_cnt3}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("midrst_idle_enable", {31'd0, if3.enable}, 32'd0);
    end
    applyStimulus(1'b1, 32'hD0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("midrst_new_flit", if3.flit, 32'hD0);
    drain("midrst_drain");
    checkOutput("sb_empty", sb_q.size(), 32'd0);

    // RETRY_WAIT = 0: immediate re-offer, then reject counter saturation
    if0.in_valid = 1'b1;
    if0.in_flit  = 32'h99;
    tick();
    if0.in_valid = 1'b0;
    if0.rej      = 1'b1;
    tick();
    checkOutput("rw0_enable", {31'd0, if0.enable}, 32'd1);
    checkOutput("rw0_flit", if0.flit, 32'h99);
    checkOutput("rw0_rej_cnt", {16'd0, rej_cnt0}, 32'd1);
    for (int i = 0; i < 65600; i++) tick();
    checkOutput("sat_rej_cnt", {16'd0, rej_cnt0}, 32'h0000FFFF);
    checkOutput("sat_enable", {31'd0, if0.enable}, 32'd1);
    checkOutput("sat_flit", if0.flit, 32'h99);
    if0.ack = 1'b1;
    tick();
    if0.ack = 1'b0;
    if0.rej = 1'b0;
    checkOutput("sat_ack_count", {29'd0, count0}, 32'd0);
    checkOutput("sat_ack_enable", {31'd0, if0.enable}, 32'd0);
    checkOutput("sat_hold_rej_cnt", {16'd0, rej_cnt0}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
